// File: rtl/serial_subtract_ctrl.sv
// Bit-serial a - b controller: one full-subtract cell (two half subtractors) walked LSB first.
// Define SERIAL_SUB_OVF_EN to register the signed overflow flag alongside diff.
module serial_subtract_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, res;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             last, load;

    // half subtractor 1: a_bit - b_bit
    logic d1, bo1;
    assign d1  = a_sh[0] ^ b_sh[0];
    assign bo1 = ~a_sh[0] & b_sh[0];

    // half subtractor 2: d1 - borrow
    logic d2, bo2;
    assign d2  = d1 ^ brw;
    assign bo2 = ~d1 & brw;

    assign last = (cnt == LAST);
    assign load = start && (state != SHIFT);
    assign busy = (state == SHIFT);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh       <= '0;
            b_sh       <= '0;
            res        <= '0;
            cnt        <= '0;
            brw        <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (load) begin
            a_sh <= a;
            b_sh <= b;
            brw  <= 1'b0;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            a_sh <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh <= {1'b0, b_sh[WIDTH-1:1]};
            res  <= {d2, res[WIDTH-1:1]};
            brw  <= bo1 | bo2;
            if (last) begin
                diff       <= {d2, res[WIDTH-1:1]};
                borrow_out <= bo1 | bo2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // on the last bit the shift registers still hold the operand sign bits
    always_ff @(posedge clk) begin
        if (rst)
            overflow <= 1'b0;
        else if (state == SHIFT && last)
            overflow <= (a_sh[0] ^ b_sh[0]) & (d2 ^ a_sh[0]);
    end
`else
    assign overflow = 1'b0;
`endif

endmodule
